// File: rtl/ser2par_pkg.sv
// ============================================================================
// Module      : ser2par_pkg
// Description : Shared types and helpers for the serial-to-parallel loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser2par_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Counter must be able to represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser2par_loader_if.sv
// ============================================================================
// Module      : ser2par_loader_if
// Description : Serial input handshake plus register-side outputs of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ser2par_loader_if #(
  parameter int WIDTH = ser2par_pkg::DEFAULT_WIDTH
) ();

  logic             s_valid;
  logic             s_bit;
  logic             s_last;
  logic             s_ready;
  logic             clr_req;
  logic [WIDTH-1:0] data;
  logic             load;
  logic             reg_clr;
  logic             frame_err;
  logic             busy;

  modport master (
    output s_valid, s_bit, s_last, clr_req,
    input  s_ready, data, load, reg_clr, frame_err, busy
  );

  modport slave (
    input  s_valid, s_bit, s_last, clr_req,
    output s_ready, data, load, reg_clr, frame_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/ser2par_shreg.sv
// ============================================================================
// Module      : ser2par_shreg
// Description : Directional assembly shift register with sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser2par_shreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // q_next is the value after shifting din in, used to publish a word in the
  // same edge that completes it.
  generate
    if (WIDTH == 1) begin : g_single
      assign w_next = din;
    end else if (MSB_FIRST) begin : g_msb
      assign w_next = {r_q[WIDTH-2:0], din};
    end else begin : g_lsb
      assign w_next = {din, r_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= w_next;
    end
  end

  assign q      = r_q;
  assign q_next = w_next;

endmodule

`default_nettype wire

// File: rtl/ser2par_loader.sv
// ============================================================================
// Module      : ser2par_loader
// Description : Assembles serial frames into words; drives load/clear pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser2par_loader
  import ser2par_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_,
  ser2par_loader_if.slave       bus
);

  localparam int                 c_CNT_W    = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(WIDTH - 1);

  state_e             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_count, w_count_nxt, w_count_base;
  logic [WIDTH-1:0]   r_data, w_data_nxt;
  logic [WIDTH-1:0]   w_word, w_word_nxt;
  logic               r_reg_clr, r_frame_err, w_frame_err_nxt;
  logic               w_ready, w_accept, w_shift_en, w_shreg_clr;

  assign w_ready  = reset_ && (r_state != ST_LOAD);
  assign w_accept = bus.s_valid && w_ready;

  ser2par_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .reset_   (reset_),
    .shift_en (w_shift_en),
    .clr      (w_shreg_clr),
    .din      (bus.s_bit),
    .q        (w_word),
    .q_next   (w_word_nxt)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_data      <= '0;
      r_reg_clr   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_data      <= w_data_nxt;
      r_reg_clr   <= bus.clr_req;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Bits already held before the current one; IDLE always starts a new frame.
  assign w_count_base = (r_state == ST_SHIFT) ? r_count : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_data_nxt      = r_data;
    w_frame_err_nxt = 1'b0;
    w_shift_en      = 1'b0;
    w_shreg_clr     = 1'b0;
    if (bus.clr_req) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_data_nxt  = '0;
      w_shreg_clr = 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: w_state_nxt = ST_IDLE;
        default: begin
          if (w_accept) begin
            if (w_count_base == c_LAST_IDX) begin
              w_count_nxt = '0;
              w_shreg_clr = 1'b1;
              if (bus.s_last) begin
                w_state_nxt = ST_LOAD;
                w_data_nxt  = w_word_nxt;
              end else begin
                w_state_nxt     = ST_IDLE;
                w_frame_err_nxt = 1'b1;
              end
            end else if (bus.s_last) begin
              w_state_nxt     = ST_IDLE;
              w_count_nxt     = '0;
              w_shreg_clr     = 1'b1;
              w_frame_err_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_SHIFT;
              w_count_nxt = w_count_base + 1'b1;
              w_shift_en  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.s_ready   = w_ready;
    bus.load      = (r_state == ST_LOAD);
    bus.busy      = (r_state == ST_SHIFT);
    bus.data      = r_data;
    bus.reg_clr   = r_reg_clr;
    bus.frame_err = r_frame_err;
  end

  // The assembly register is only observed through q_next.
  logic w_unused_word;
  assign w_unused_word = ^w_word;

endmodule

`default_nettype wire
